// File: rtl/gopher_game_pkg.sv
// rtl/gopher_game_pkg.sv - shared state encoding, default parameters and saturating add
package gopher_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_WAIT_INPUT = 3'd2,
    ST_CHECK      = 3'd3,
    ST_DELAY      = 3'd4,
    ST_ROUND_END  = 3'd5,
    ST_GAME_OVER  = 3'd6
  } state_t;

  localparam int DEF_N_HOLES      = 16;
  localparam int DEF_TIMER_W      = 26;
  localparam int DEF_INIT_TIMEOUT = 1000;
  localparam int DEF_TIMEOUT_STEP = 100;
  localparam int DEF_MIN_TIMEOUT  = 200;
  localparam int DEF_DELAY_CYCLES = 50;
  localparam int DEF_SCORE_W      = 16;
  localparam int DEF_ROUND_W      = 4;
  localparam int DEF_LIVES        = 3;

  // a + b clamped to the all-ones value of a width-bit field
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int width);
    logic [32:0] sum;
    logic [32:0] max_v;
    sum   = {1'b0, a} + {1'b0, b};
    max_v = (33'd1 << width) - 33'd1;
    return (sum > max_v) ? max_v[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/game_down_timer.sv
// rtl/game_down_timer.sv - loadable down-counter that holds at zero
module game_down_timer #(
  parameter int TIMER_W = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic [TIMER_W-1:0] load_value,
  output logic               zero
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // load has priority over counting; the count never wraps below zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/gopher_game_ctrl.sv
// rtl/gopher_game_ctrl.sv - whack-a-mole sequencer; BONUS_LIFE_EN adds a clean-round extra life
module gopher_game_ctrl
  import gopher_game_pkg::*;
#(
  parameter int N_HOLES      = DEF_N_HOLES,
  parameter int TIMER_W      = DEF_TIMER_W,
  parameter int INIT_TIMEOUT = DEF_INIT_TIMEOUT,
  parameter int TIMEOUT_STEP = DEF_TIMEOUT_STEP,
  parameter int MIN_TIMEOUT  = DEF_MIN_TIMEOUT,
  parameter int DELAY_CYCLES = DEF_DELAY_CYCLES,
  parameter int SCORE_W      = DEF_SCORE_W,
  parameter int ROUND_W      = DEF_ROUND_W,
  parameter int LIVES        = DEF_LIVES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_game,
  output logic                         us_req,
  output logic                         us_restart,
  input  logic [$clog2(N_HOLES)-1:0]   us_number,
  input  logic                         us_done,
  input  logic                         us_all_selected,
  input  logic                         user_valid,
  input  logic [$clog2(N_HOLES)-1:0]   user_number,
  output logic [$clog2(N_HOLES)-1:0]   target_number,
  output logic                         target_valid,
  output logic                         hit,
  output logic                         miss,
  output logic                         round_done,
  output logic [SCORE_W-1:0]           score,
  output logic [ROUND_W-1:0]           round,
  output logic [$clog2(LIVES+1)-1:0]   lives,
  output logic                         game_over
);

  localparam int HOLE_W = $clog2(N_HOLES);
  localparam int LIFE_W = $clog2(LIVES + 1);

  localparam logic [TIMER_W-1:0] INIT_T = TIMER_W'(INIT_TIMEOUT);
  localparam logic [TIMER_W-1:0] STEP_T = TIMER_W'(TIMEOUT_STEP);
  localparam logic [TIMER_W-1:0] MIN_T  = TIMER_W'(MIN_TIMEOUT);
  localparam logic [TIMER_W:0]   STEP_PLUS_MIN =
    (TIMER_W+1)'(TIMEOUT_STEP) + (TIMER_W+1)'(MIN_TIMEOUT);
  // timers expire on the cycle their count is zero, so they are loaded with N-1
  localparam logic [TIMER_W-1:0] DELAY_LOAD =
    (DELAY_CYCLES == 0) ? '0 : TIMER_W'(DELAY_CYCLES - 1);
  localparam logic [LIFE_W-1:0]  LIVES_L = LIFE_W'(LIVES);

  state_t              state_q,        state_d;
  logic [HOLE_W-1:0]   target_q,       target_d;
  logic [HOLE_W-1:0]   user_q,         user_d;
  logic                pressed_q,      pressed_d;
  logic                tvalid_q,       tvalid_d;
  logic                us_req_q,       us_req_d;
  logic                us_restart_q,   us_restart_d;
  logic                hit_q,          hit_d;
  logic                miss_q,         miss_d;
  logic                round_done_q,   round_done_d;
  logic [SCORE_W-1:0]  score_q,        score_d;
  logic [ROUND_W-1:0]  round_q,        round_d;
  logic [LIFE_W-1:0]   lives_q,        lives_d;
  logic                game_over_q,    game_over_d;
  logic [TIMER_W-1:0]  cur_timeout_q,  cur_timeout_d;
`ifdef BONUS_LIFE_EN
  logic                clean_round_q,  clean_round_d;
`endif

  logic                react_load;
  logic                react_en;
  logic                react_zero;
  logic [TIMER_W-1:0]  react_load_value;
  logic                delay_load;
  logic                delay_en;
  logic                delay_zero;
  logic [LIFE_W-1:0]   lives_next;
  logic                is_hit;

  assign react_load_value = (cur_timeout_q == '0) ? '0 : cur_timeout_q - TIMER_W'(1);

  game_down_timer #(.TIMER_W(TIMER_W)) u_react_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (react_load),
    .en         (react_en),
    .load_value (react_load_value),
    .zero       (react_zero)
  );

  game_down_timer #(.TIMER_W(TIMER_W)) u_delay_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (delay_load),
    .en         (delay_en),
    .load_value (DELAY_LOAD),
    .zero       (delay_zero)
  );

  // next-state and next-output computation for the game sequencer
  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    user_d         = user_q;
    pressed_d      = pressed_q;
    tvalid_d       = tvalid_q;
    us_req_d       = us_req_q;
    us_restart_d   = 1'b0;
    hit_d          = 1'b0;
    miss_d         = 1'b0;
    round_done_d   = 1'b0;
    score_d        = score_q;
    round_d        = round_q;
    lives_d        = lives_q;
    game_over_d    = game_over_q;
    cur_timeout_d  = cur_timeout_q;
`ifdef BONUS_LIFE_EN
    clean_round_d  = clean_round_q;
`endif
    react_load     = 1'b0;
    react_en       = 1'b0;
    delay_load     = 1'b0;
    delay_en       = 1'b0;
    lives_next     = lives_q;
    is_hit         = pressed_q && (user_q == target_q);

    unique case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_game) begin
          score_d       = '0;
          round_d       = '0;
          lives_d       = LIVES_L;
          cur_timeout_d = INIT_T;
          game_over_d   = 1'b0;
          us_restart_d  = 1'b1;
          us_req_d      = 1'b1;
`ifdef BONUS_LIFE_EN
          clean_round_d = 1'b1;
`endif
          state_d       = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (us_done) begin
          target_d   = us_number;
          react_load = 1'b1;
          us_req_d   = 1'b0;
          tvalid_d   = 1'b1;
          state_d    = ST_WAIT_INPUT;
        end
      end

      ST_WAIT_INPUT: begin
        react_en = 1'b1;
        // a press in the expiry cycle still counts as a press
        if (user_valid) begin
          user_d    = user_number;
          pressed_d = 1'b1;
          tvalid_d  = 1'b0;
          state_d   = ST_CHECK;
        end else if (react_zero) begin
          pressed_d = 1'b0;
          tvalid_d  = 1'b0;
          state_d   = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (is_hit) begin
          hit_d   = 1'b1;
          score_d = SCORE_W'(sat_add(32'(score_q), 32'(round_q) + 32'd1, SCORE_W));
        end else begin
          miss_d     = 1'b1;
          lives_next = (lives_q != '0) ? lives_q - LIFE_W'(1) : '0;
          lives_d    = lives_next;
`ifdef BONUS_LIFE_EN
          clean_round_d = 1'b0;
`endif
        end
        if (lives_next == '0) begin
          game_over_d = 1'b1;
          state_d     = ST_GAME_OVER;
        end else if (us_all_selected) begin
          state_d = ST_ROUND_END;
        end else begin
          delay_load = 1'b1;
          state_d    = ST_DELAY;
        end
      end

      ST_ROUND_END: begin
        round_done_d = 1'b1;
        us_restart_d = 1'b1;
        round_d      = ROUND_W'(sat_add(32'(round_q), 32'd1, ROUND_W));
        if ({1'b0, cur_timeout_q} >= STEP_PLUS_MIN) begin
          cur_timeout_d = cur_timeout_q - STEP_T;
        end else begin
          cur_timeout_d = MIN_T;
        end
`ifdef BONUS_LIFE_EN
        if (clean_round_q && (lives_q < LIVES_L)) begin
          lives_d = lives_q + LIFE_W'(1);
        end
        clean_round_d = 1'b1;
`else
        lives_d = lives_q;
`endif
        delay_load = 1'b1;
        state_d    = ST_DELAY;
      end

      ST_DELAY: begin
        delay_en = 1'b1;
        if (delay_zero) begin
          us_req_d = 1'b1;
          state_d  = ST_LOAD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      target_q      <= '0;
      user_q        <= '0;
      pressed_q     <= 1'b0;
      tvalid_q      <= 1'b0;
      us_req_q      <= 1'b0;
      us_restart_q  <= 1'b0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
      round_done_q  <= 1'b0;
      score_q       <= '0;
      round_q       <= '0;
      lives_q       <= LIVES_L;
      game_over_q   <= 1'b0;
      cur_timeout_q <= INIT_T;
`ifdef BONUS_LIFE_EN
      clean_round_q <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      user_q        <= user_d;
      pressed_q     <= pressed_d;
      tvalid_q      <= tvalid_d;
      us_req_q      <= us_req_d;
      us_restart_q  <= us_restart_d;
      hit_q         <= hit_d;
      miss_q        <= miss_d;
      round_done_q  <= round_done_d;
      score_q       <= score_d;
      round_q       <= round_d;
      lives_q       <= lives_d;
      game_over_q   <= game_over_d;
      cur_timeout_q <= cur_timeout_d;
`ifdef BONUS_LIFE_EN
      clean_round_q <= clean_round_d;
`endif
    end
  end

  assign us_req        = us_req_q;
  assign us_restart    = us_restart_q;
  assign target_number = target_q;
  assign target_valid  = tvalid_q;
  assign hit           = hit_q;
  assign miss          = miss_q;
  assign round_done    = round_done_q;
  assign score         = score_q;
  assign round         = round_q;
  assign lives         = lives_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_gopher_game_ctrl.sv
// tb/tb_gopher_game_ctrl.sv - table-driven bench for gopher_game_ctrl (BONUS_LIFE_EN aware)
module tb_gopher_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_game;
  logic       us_req;
  logic       us_restart;
  logic [3:0] us_number;
  logic       us_done;
  logic       us_all_selected;
  logic       user_valid;
  logic [3:0] user_number;
  logic [3:0] target_number;
  logic       target_valid;
  logic       hit;
  logic       miss;
  logic       round_done;
  logic [15:0] score;
  logic [3:0] round;
  logic [1:0] lives;
  logic       game_over;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int sel;       int do_press;  int press_val; int wait_k;   int all_sel;
    int exp_gap;   int exp_win;   int exp_hit;   int exp_miss; int exp_score;
    int exp_lives; int exp_lives_rd; int exp_round; int exp_over;
  } vec_t;

  vec_t tbl[$];

  gopher_game_ctrl #(
    .N_HOLES(16), .TIMER_W(26), .INIT_TIMEOUT(1000), .TIMEOUT_STEP(100),
    .MIN_TIMEOUT(200), .DELAY_CYCLES(50), .SCORE_W(16), .ROUND_W(4), .LIVES(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_game(start_game),
    .us_req(us_req), .us_restart(us_restart), .us_number(us_number),
    .us_done(us_done), .us_all_selected(us_all_selected),
    .user_valid(user_valid), .user_number(user_number),
    .target_number(target_number), .target_valid(target_valid),
    .hit(hit), .miss(miss), .round_done(round_done),
    .score(score), .round(round), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // one gopher: serve a hole, press or let it expire, then inspect the outcome
  task automatic play(input vec_t v);
    int gap;
    int win;
    gap = 0;
    while (!us_req && gap < 300) begin
      tick();
      gap++;
    end
    check("gap_to_req", gap, v.exp_gap);
    us_done = 1'b1; us_number = 4'(v.sel);
    tick();
    us_done = 1'b0;
    check("tvalid_latency", int'(target_valid), 1);
    check("target_number", int'(target_number), v.sel);
    check("us_req_drop", int'(us_req), 0);
    if (v.do_press != 0) begin
      repeat (v.wait_k) tick();
      check("press_in_window", int'(target_valid), 1);
      user_valid = 1'b1; user_number = 4'(v.press_val);
      tick();
      user_valid = 1'b0;
    end else begin
      win = 1;
      while (target_valid && win < 2000) begin
        tick();
        if (target_valid) win++;
      end
      check("window", win, v.exp_win);
    end
    us_all_selected = (v.all_sel != 0);
    tick();
    us_all_selected = 1'b0;
    check("hit", int'(hit), v.exp_hit);
    check("miss", int'(miss), v.exp_miss);
    check("score", int'(score), v.exp_score);
    check("lives", int'(lives), v.exp_lives);
    check("game_over", int'(game_over), v.exp_over);
    if (v.all_sel != 0 && v.exp_over == 0) begin
      tick();
      check("round_done", int'(round_done), 1);
      check("round_restart", int'(us_restart), 1);
      check("hit_one_cycle", int'(hit), 0);
      check("lives_after_round", int'(lives), v.exp_lives_rd);
    end else begin
      check("no_round_done", int'(round_done), 0);
    end
    check("round", int'(round), v.exp_round);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_game = 1'b0; us_number = '0; us_done = 1'b0;
    us_all_selected = 1'b0; user_valid = 1'b0; user_number = '0;

`ifdef BONUS_LIFE_EN
    //              sel p pv k al gap win h m sc L Lrd R over
    tbl.push_back('{5, 1, 7, 0, 1, 0,  0, 0, 1, 0, 2, 2, 1, 0});
    tbl.push_back('{6, 1, 6, 0, 1, 50, 0, 1, 0, 2, 2, 3, 2, 0});
    tbl.push_back('{7, 1, 7, 0, 1, 50, 0, 1, 0, 5, 3, 3, 3, 0});
`else
    tbl.push_back('{5,  1, 5,  1,   0, 0,  0,    1, 0, 1,  3, 3, 0, 0});
    tbl.push_back('{6,  0, 0,  0,   0, 50, 1000, 0, 1, 1,  2, 2, 0, 0});
    tbl.push_back('{9,  1, 9,  999, 1, 50, 0,    1, 0, 2,  2, 2, 1, 0});
    tbl.push_back('{1,  0, 0,  0,   0, 50, 900,  0, 1, 2,  1, 1, 1, 0});
    tbl.push_back('{2,  1, 2,  0,   1, 50, 0,    1, 0, 4,  1, 1, 2, 0});
    tbl.push_back('{3,  1, 3,  5,   1, 50, 0,    1, 0, 7,  1, 1, 3, 0});
    tbl.push_back('{4,  1, 4,  0,   1, 50, 0,    1, 0, 11, 1, 1, 4, 0});
    tbl.push_back('{7,  1, 7,  0,   1, 50, 0,    1, 0, 16, 1, 1, 5, 0});
    tbl.push_back('{8,  1, 8,  0,   1, 50, 0,    1, 0, 22, 1, 1, 6, 0});
    tbl.push_back('{10, 1, 10, 0,   1, 50, 0,    1, 0, 29, 1, 1, 7, 0});
    tbl.push_back('{11, 1, 11, 0,   1, 50, 0,    1, 0, 37, 1, 1, 8, 0});
    tbl.push_back('{12, 1, 12, 199, 1, 50, 0,    1, 0, 46, 1, 1, 9, 0});
    tbl.push_back('{13, 0, 0,  0,   0, 50, 200,  0, 1, 46, 0, 0, 9, 1});
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_lives", int'(lives), 3);
    check("rst_score", int'(score), 0);
    check("rst_round", int'(round), 0);
    check("rst_us_req", int'(us_req), 0);
    check("rst_tvalid", int'(target_valid), 0);
    check("rst_game_over", int'(game_over), 0);
    rst_n = 1'b1;
    tick();
    check("idle_no_req", int'(us_req), 0);

    start_game = 1'b1;
    tick();
    start_game = 1'b0;
    check("start_restart", int'(us_restart), 1);
    check("start_req", int'(us_req), 1);
    tick();
    check("restart_one_cycle", int'(us_restart), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      play(tbl[i]);
    end

`ifndef BONUS_LIFE_EN
    // frozen in GAME_OVER: presses and selector acks do nothing
    repeat (3) begin
      user_valid = 1'b1; user_number = 4'd13; us_done = 1'b1; us_number = 4'd2;
      tick();
    end
    user_valid = 1'b0; us_done = 1'b0;
    check("go_score_frozen", int'(score), 46);
    check("go_lives", int'(lives), 0);
    check("go_round", int'(round), 9);
    check("go_hit", int'(hit), 0);
    check("go_miss", int'(miss), 0);
    check("go_level", int'(game_over), 1);
    check("go_tvalid", int'(target_valid), 0);
    check("go_us_req", int'(us_req), 0);

    start_game = 1'b1;
    tick();
    start_game = 1'b0;
    check("restart_pulse", int'(us_restart), 1);
    check("restart_lives", int'(lives), 3);
    check("restart_score", int'(score), 0);
    check("restart_round", int'(round), 0);
    check("restart_go_clear", int'(game_over), 0);
    tick();
    play('{5, 1, 7, 0, 0, 0, 0, 0, 1, 0, 2, 2, 0, 0});

    // asynchronous reset in the middle of DELAY
    #2;
    rst_n = 1'b0;
    #1;
    check("async_lives", int'(lives), 3);
    check("async_miss", int'(miss), 0);
    check("async_req", int'(us_req), 0);
    #3;
    rst_n = 1'b1;
    repeat (60) tick();
    check("after_reset_idle", int'(us_req), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
